// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared encodings for the KLP32 multicycle controller.
// Holds the RV32I opcode constants and the imm_sel codes shared with immgen.
// Also holds the ALU source, alu_op and result_src mux encodings, and the
// controller state enum.
// The TRAP state exists only when MC_ILLEGAL_TRAP_EN is defined.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_PC     = 2'b11;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECR,
    ST_EXECI,
    ST_EXECU,
    ST_ALUWB,
    ST_BRANCH,
    ST_JALRADR,
    ST_JUMP
`ifdef MC_ILLEGAL_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational control-word decoder for mc_control.
// Inputs : state, opcode, br_taken, mem_ready
// Outputs: memory handshake, write strobes, mux selects, imm_sel, alu_op and
//          illegal.
// When MC_ILLEGAL_TRAP_EN is defined, illegal is driven high in the TRAP state.
// Otherwise illegal is tied 0.
// This block does no reset masking; the top module does it.
module mc_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal
);

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    imm_sel    = IMM_I;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    illegal    = 1'b0;
    case (state)
      ST_FETCH: begin
        // PC+4 is computed every fetch cycle; it is only committed once
        // memory completes.
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        // Branch/jump target oldPC+imm is speculatively latched into ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (opcode == OPC_BRANCH)   imm_sel = IMM_B;
        else if (opcode == OPC_JAL) imm_sel = IMM_J;
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (opcode == OPC_STORE) imm_sel = IMM_S;
      end
      ST_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
      end
      ST_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      ST_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      ST_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      ST_EXECU: begin
        // LUI adds the U-immediate to zero; AUIPC adds it to oldPC.
        imm_sel   = IMM_U;
        alu_src_b = SRCB_IMM;
        alu_src_a = (opcode == OPC_LUI) ? SRCA_ZERO : SRCA_OLDPC;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        pc_write  = br_taken;
        pc_src    = 1'b1;
      end
      ST_JALRADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      ST_JUMP: begin
        // PC already holds oldPC+4 from fetch, so it is the link value.
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP: begin
        illegal = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle Moore sequencer for the KLP32 RV32I core.
// Ports: clk, reset (synchronous, active-high); opcode, br_taken and mem_ready
//        in; memory handshake, datapath strobes, mux selects, imm_sel,
//        alu_op and illegal out.
// Optional MC_ILLEGAL_TRAP_EN: an unknown opcode locks the controller in TRAP,
// with illegal=1, until reset. When it is undefined, an unknown opcode is
// executed as a 2-cycle NOP.
module mc_control
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal
);

  state_t state_q, state_d;

  logic       dec_mem_req, dec_mem_we, dec_adr_src, dec_ir_write;
  logic       dec_pc_write, dec_pc_src, dec_reg_write, dec_illegal;
  logic [2:0] dec_imm_sel;
  logic [1:0] dec_alu_src_a, dec_alu_src_b, dec_alu_op, dec_result_src;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = ST_MEMADR;
          OPC_OP:              state_d = ST_EXECR;
          OPC_OP_IMM:          state_d = ST_EXECI;
          OPC_LUI, OPC_AUIPC:  state_d = ST_EXECU;
          OPC_BRANCH:          state_d = ST_BRANCH;
          OPC_JAL:             state_d = ST_JUMP;
          OPC_JALR:            state_d = ST_JALRADR;
`ifdef MC_ILLEGAL_TRAP_EN
          default:             state_d = ST_TRAP;
`else
          default:             state_d = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADR:   state_d = (opcode == OPC_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
      ST_EXECR:    state_d = ST_ALUWB;
      ST_EXECI:    state_d = ST_ALUWB;
      ST_EXECU:    state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JALRADR:  state_d = ST_JUMP;
      ST_JUMP:     state_d = ST_FETCH;
      default:     state_d = state_q;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .br_taken   (br_taken),
    .mem_ready  (mem_ready),
    .mem_req    (dec_mem_req),
    .mem_we     (dec_mem_we),
    .adr_src    (dec_adr_src),
    .ir_write   (dec_ir_write),
    .pc_write   (dec_pc_write),
    .pc_src     (dec_pc_src),
    .reg_write  (dec_reg_write),
    .imm_sel    (dec_imm_sel),
    .alu_src_a  (dec_alu_src_a),
    .alu_src_b  (dec_alu_src_b),
    .alu_op     (dec_alu_op),
    .result_src (dec_result_src),
    .illegal    (dec_illegal)
  );

  // Reset forces every output low immediately. This way an instruction that
  // is abandoned mid-flight cannot commit a write in the reset cycle.
  always_comb begin
    mem_req    = dec_mem_req    & ~reset;
    mem_we     = dec_mem_we     & ~reset;
    adr_src    = dec_adr_src    & ~reset;
    ir_write   = dec_ir_write   & ~reset;
    pc_write   = dec_pc_write   & ~reset;
    pc_src     = dec_pc_src     & ~reset;
    reg_write  = dec_reg_write  & ~reset;
    illegal    = dec_illegal    & ~reset;
    imm_sel    = reset ? 3'b000 : dec_imm_sel;
    alu_src_a  = reset ? 2'b00  : dec_alu_src_a;
    alu_src_b  = reset ? 2'b00  : dec_alu_src_b;
    alu_op     = reset ? 2'b00  : dec_alu_op;
    result_src = reset ? 2'b00  : dec_result_src;
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed self-checking bench for mc_control.
// Each cycle drives opcode, mem_ready and br_taken, then compares the packed
// 19-bit control word against a hand-built expected word.
// Expectations for the unknown-opcode case follow MC_ILLEGAL_TRAP_EN.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       br_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write;
  logic [2:0] imm_sel;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       illegal;
  logic [18:0] ctrlWord;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .br_taken   (br_taken),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .imm_sel    (imm_sel),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .illegal    (illegal)
  );

  assign ctrlWord = {mem_req, mem_we, adr_src, ir_write, pc_write, pc_src,
                     reg_write, imm_sel, alu_src_a, alu_src_b, alu_op,
                     result_src, illegal};

  // Packs one expected control word in the same field order as ctrlWord.
  function automatic logic [18:0] cw(input logic req, input logic we,
                                     input logic adr, input logic irw,
                                     input logic pcw, input logic pcs,
                                     input logic rw, input logic [2:0] imm,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op,
                                     input logic [1:0] res, input logic ill);
    return {req, we, adr, irw, pcw, pcs, rw, imm, a, b, op, res, ill};
  endfunction

  // Compares one observed value with its expected value and counts it.
  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %05h expected %05h", tag, act, exp);
    end
  endtask

  // Drives the inputs for one cycle, then lets the combinational outputs settle.
  task automatic applyStimulus(input logic [6:0] op, input logic rdy,
                               input logic tk);
    opcode    = op;
    mem_ready = rdy;
    br_taken  = tk;
    #1;
  endtask

  // Runs one cycle: drive, compare away from the edge, then advance the clock.
  task automatic cycleCheck(input string tag, input logic [6:0] op,
                            input logic rdy, input logic tk,
                            input logic [18:0] exp);
    applyStimulus(op, rdy, tk);
    checkOutput(tag, {13'b0, ctrlWord}, {13'b0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [18:0] fetchGo, fetchWait, decodeI, aluWb, jumpWord;

  initial begin
    fetchGo   = cw(1,0,0,1,1,0,0,3'b000,2'b00,2'b10,2'b00,2'b00,0);
    fetchWait = cw(1,0,0,0,0,0,0,3'b000,2'b00,2'b10,2'b00,2'b00,0);
    decodeI   = cw(0,0,0,0,0,0,0,3'b000,2'b01,2'b01,2'b00,2'b00,0);
    aluWb     = cw(0,0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b00,2'b00,0);
    jumpWord  = cw(0,0,0,0,1,1,1,3'b000,2'b00,2'b00,2'b00,2'b11,0);

    reset = 1'b1;
    applyStimulus(7'b0110011, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {13'b0, ctrlWord}, 32'd0);
    reset = 1'b0;

    // R-type, zero-wait memory: 4 cycles
    cycleCheck("r_fetch",  7'b0110011, 1, 0, fetchGo);
    cycleCheck("r_decode", 7'b0110011, 1, 0, decodeI);
    cycleCheck("r_exec",   7'b0110011, 1, 0,
               cw(0,0,0,0,0,0,0,3'b000,2'b10,2'b00,2'b10,2'b00,0));
    cycleCheck("r_wb",     7'b0110011, 1, 0, aluWb);

    // LOAD with 2 fetch waits and 1 read wait: 8 cycles
    cycleCheck("ld_fwait1", 7'b0000011, 0, 0, fetchWait);
    cycleCheck("ld_fwait2", 7'b0000011, 0, 0, fetchWait);
    cycleCheck("ld_fetch",  7'b0000011, 1, 0, fetchGo);
    cycleCheck("ld_decode", 7'b0000011, 1, 0, decodeI);
    cycleCheck("ld_memadr", 7'b0000011, 1, 0,
               cw(0,0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b00,2'b00,0));
    cycleCheck("ld_rwait",  7'b0000011, 0, 0,
               cw(1,0,1,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0));
    cycleCheck("ld_read",   7'b0000011, 1, 0,
               cw(1,0,1,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0));
    cycleCheck("ld_wb",     7'b0000011, 1, 0,
               cw(0,0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b00,2'b01,0));

    // BRANCH not taken, then taken: 3 cycles each
    for (int t = 0; t < 2; t++) begin
      cycleCheck("br_fetch",  7'b1100011, 1, t[0], fetchGo);
      cycleCheck("br_decode", 7'b1100011, 1, t[0],
                 cw(0,0,0,0,0,0,0,3'b010,2'b01,2'b01,2'b00,2'b00,0));
      cycleCheck(t == 0 ? "br_nottaken" : "br_taken", 7'b1100011, 1, t[0],
                 cw(0,0,0,0,t[0],1,0,3'b000,2'b10,2'b00,2'b01,2'b00,0));
    end

    // JAL: 3 cycles
    cycleCheck("jal_fetch",  7'b1101111, 1, 0, fetchGo);
    cycleCheck("jal_decode", 7'b1101111, 1, 0,
               cw(0,0,0,0,0,0,0,3'b100,2'b01,2'b01,2'b00,2'b00,0));
    cycleCheck("jal_jump",   7'b1101111, 1, 0, jumpWord);

    // JALR: 4 cycles
    cycleCheck("jalr_fetch",  7'b1100111, 1, 0, fetchGo);
    cycleCheck("jalr_decode", 7'b1100111, 1, 0, decodeI);
    cycleCheck("jalr_adr",    7'b1100111, 1, 0,
               cw(0,0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b00,2'b00,0));
    cycleCheck("jalr_jump",   7'b1100111, 1, 0, jumpWord);

    // LUI then AUIPC: 4 cycles each, differing only in the A source
    cycleCheck("lui_fetch",  7'b0110111, 1, 0, fetchGo);
    cycleCheck("lui_decode", 7'b0110111, 1, 0, decodeI);
    cycleCheck("lui_exec",   7'b0110111, 1, 0,
               cw(0,0,0,0,0,0,0,3'b011,2'b11,2'b01,2'b00,2'b00,0));
    cycleCheck("lui_wb",     7'b0110111, 1, 0, aluWb);
    cycleCheck("auipc_fetch",  7'b0010111, 1, 0, fetchGo);
    cycleCheck("auipc_decode", 7'b0010111, 1, 0, decodeI);
    cycleCheck("auipc_exec",   7'b0010111, 1, 0,
               cw(0,0,0,0,0,0,0,3'b011,2'b01,2'b01,2'b00,2'b00,0));
    cycleCheck("auipc_wb",     7'b0010111, 1, 0, aluWb);

    // OP-IMM: 4 cycles
    cycleCheck("opi_fetch",  7'b0010011, 1, 0, fetchGo);
    cycleCheck("opi_decode", 7'b0010011, 1, 0, decodeI);
    cycleCheck("opi_exec",   7'b0010011, 1, 0,
               cw(0,0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b10,2'b00,0));
    cycleCheck("opi_wb",     7'b0010011, 1, 0, aluWb);

    // STORE interrupted by reset while MEMWRITE waits
    cycleCheck("st_fetch",  7'b0100011, 1, 0, fetchGo);
    cycleCheck("st_decode", 7'b0100011, 1, 0, decodeI);
    cycleCheck("st_memadr", 7'b0100011, 1, 0,
               cw(0,0,0,0,0,0,0,3'b001,2'b10,2'b01,2'b00,2'b00,0));
    cycleCheck("st_wwait",  7'b0100011, 0, 0,
               cw(1,1,1,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0));
    reset = 1'b1;
    applyStimulus(7'b0100011, 1'b0, 1'b0);
    checkOutput("st_reset_outputs", {13'b0, ctrlWord}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycleCheck("st_refetch", 7'b0100011, 0, 0, fetchWait);
    cycleCheck("st_refetch_go", 7'b0100011, 1, 0, fetchGo);
    cycleCheck("st_redecode", 7'b0100011, 1, 0, decodeI);
    cycleCheck("st_rememadr", 7'b0100011, 1, 0,
               cw(0,0,0,0,0,0,0,3'b001,2'b10,2'b01,2'b00,2'b00,0));
    cycleCheck("st_write", 7'b0100011, 1, 0,
               cw(1,1,1,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0));

    // Unknown opcode 1111111
    cycleCheck("ill_fetch",  7'b1111111, 1, 0, fetchGo);
    cycleCheck("ill_decode", 7'b1111111, 1, 0, decodeI);
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++)
      cycleCheck("ill_trap", 7'b1111111, i[0], 0,
                 cw(0,0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,1));
    reset = 1'b1;
    applyStimulus(7'b1111111, 1'b1, 1'b0);
    checkOutput("ill_reset_outputs", {13'b0, ctrlWord}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycleCheck("ill_after_reset", 7'b0110011, 1, 0, fetchGo);
`else
    cycleCheck("ill_nop_fetch", 7'b0110011, 1, 0, fetchGo);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
